// File: rtl/modulo_registrador_m_at_if.sv
// Row-capture bus for modulo_registrador_m_at.
// The producer side drives rows over a valid/ready handshake, plus a synchronous clear.
// The consumer side receives the assembled word together with its valid/ack pair.
// The two counters are carried here as well so that a single bundle describes the block.
//   master : producer/consumer environment (drives clear, row_in, row_valid, m_at_ack)
//   slave  : capture stage (drives row_ready, m_at, m_at_valid, row_count, frame_count)
interface modulo_registrador_m_at_if #(
    parameter int unsigned ROW_W = 6,
    parameter int unsigned ROWS  = 6
);
    localparam int unsigned WordW = ROW_W * ROWS;

    logic             clear;
    logic [ROW_W-1:0] row_in;
    logic             row_valid;
    logic             row_ready;
    logic [WordW-1:0] m_at;
    logic             m_at_valid;
    logic             m_at_ack;
    logic [2:0]       row_count;
    logic [7:0]       frame_count;

    modport master (
        output clear, row_in, row_valid, m_at_ack,
        input  row_ready, m_at, m_at_valid, row_count, frame_count
    );

    modport slave (
        input  clear, row_in, row_valid, m_at_ack,
        output row_ready, m_at, m_at_valid, row_count, frame_count
    );
endinterface

// File: rtl/modulo_registrador_m_at.sv
// Capture stage for the 36-bit current-matrix word m_at.
// Six rows are shifted in MSB-first. The first row lands in m_at[35:30] and the last in m_at[5:0].
// Once the word is complete it is held with m_at_valid set until the consumer acks it.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   bus_io : slave side of modulo_registrador_m_at_if, which carries
//            clear, row_in, row_valid, row_ready, m_at, m_at_valid, m_at_ack,
//            row_count and frame_count
module modulo_registrador_m_at #(
    parameter int unsigned ROW_W = 6,
    parameter int unsigned ROWS  = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    modulo_registrador_m_at_if.slave     bus_io
);
    localparam int unsigned WordW = ROW_W * ROWS;

    typedef enum logic [0:0] {StLoad, StHold} state_e;

    state_e           state_q, state_d;
    logic [WordW-1:0] m_at_q, m_at_d;
    logic             m_at_valid_q, m_at_valid_d;
    logic [2:0]       row_count_q, row_count_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic             row_ready;
    logic             accept;

    // Ready depends only on state and clear, so there is no path from row_valid to row_ready.
    assign row_ready = (state_q == StLoad) && !bus_io.clear;
    assign accept    = bus_io.row_valid && row_ready;

    always_comb begin
        state_d       = state_q;
        m_at_d        = m_at_q;
        m_at_valid_d  = m_at_valid_q;
        row_count_d   = row_count_q;
        frame_count_d = frame_count_q;

        if (bus_io.clear) begin
            // Flush the partial word. frame_count keeps its history.
            state_d      = StLoad;
            m_at_d       = '0;
            m_at_valid_d = 1'b0;
            row_count_d  = '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (accept) begin
                        m_at_d = {m_at_q[WordW-ROW_W-1:0], bus_io.row_in};
                        if (row_count_q == 3'(ROWS - 1)) begin
                            row_count_d   = '0;
                            frame_count_d = frame_count_q + 8'd1;
                            m_at_valid_d  = 1'b1;
                            state_d       = StHold;
                        end else begin
                            row_count_d = row_count_q + 3'd1;
                        end
                    end
                end
                StHold: begin
                    // m_at stays in place after the ack, until the next accepted row shifts it.
                    if (bus_io.m_at_ack) begin
                        m_at_valid_d = 1'b0;
                        state_d      = StLoad;
                    end
                end
                default: state_d = StLoad;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StLoad;
            m_at_q        <= '0;
            m_at_valid_q  <= 1'b0;
            row_count_q   <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            m_at_q        <= m_at_d;
            m_at_valid_q  <= m_at_valid_d;
            row_count_q   <= row_count_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign bus_io.row_ready   = row_ready;
    assign bus_io.m_at        = m_at_q;
    assign bus_io.m_at_valid  = m_at_valid_q;
    assign bus_io.row_count   = row_count_q;
    assign bus_io.frame_count = frame_count_q;
endmodule

// File: doc/modulo_registrador_m_at.md
# modulo_registrador_m_at

Upstream capture stage for the 36-bit current-matrix word `m_at`. It assembles the word from six 6-bit rows delivered over a valid/ready handshake. It then holds the completed word stable, with `m_at_valid` asserted, until the consumer acknowledges it. Its output feeds the negation stage directly, which forms `N_m_at[34:0] = ~m_at[35:1]`.

## Interface
- `ROW_W`, default 6: bits per row.
- `ROWS`, default 6: rows per word. `ROW_W*ROWS` must equal 36.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `clear`  in  1: synchronous abort/flush.
- `row_in`  in  ROW_W: row data.
- `row_valid`  in  1: producer has a row on `row_in`.
- `row_ready`  out  1: block accepts a row this cycle (combinational).
- `m_at`  out  36: assembled word (registered).
- `m_at_valid`  out  1: `m_at` is complete and stable (registered).
- `m_at_ack`  in  1: consumer has taken `m_at`.
- `row_count`  out  3: rows accepted into the current word, 0..ROWS-1 (registered).
- `frame_count`  out  8: completed words, wraps 255→0 (registered).

## Operation
- Two states: LOAD and HOLD. Reset state is LOAD.
- **Reset values:** `m_at`=0, `m_at_valid`=0, `row_count`=0, `frame_count`=0.
- **`row_ready`** = (state==LOAD) && !`clear`.
- **Accept:** a row is accepted when `row_valid` && `row_ready`.
- **Row shift:** on accept, `m_at <= {m_at[35-ROW_W:0], row_in}`. The first row of a word ends in `m_at[35:30]` and the last row in `m_at[5:0]`.
- **LOAD, accept with `row_count` < ROWS-1:** `row_count` +1, stay in LOAD.
- **LOAD, accept with `row_count` == ROWS-1:**
  - `row_count` becomes 0.
  - `frame_count` +1 (mod 256).
  - `m_at_valid` becomes 1.
  - Go to HOLD.
- **HOLD:**
  - `row_ready`=0 and `m_at` is frozen.
  - On `m_at_ack`: `m_at_valid` becomes 0 and the state returns to LOAD.
  - `m_at` keeps its value until the next accepted row.
- **`m_at_ack` in LOAD:** ignored.
- **`row_valid` in HOLD:** not accepted. The producer must hold its data; nothing is dropped.
- **`clear` (any state):**
  - Next edge: state LOAD, `m_at`=0, `m_at_valid`=0, `row_count`=0.
  - `frame_count` is unchanged.
  - `clear` overrides any simultaneous accept or `m_at_ack`.
- **`rst`:** asynchronous and highest priority. Asserted mid-word or mid-HOLD, it immediately forces all reset values, and the partial word is discarded.
- **Consumer rule:** `m_at` is meaningful only while `m_at_valid`=1. During LOAD it shows partially shifted data.

## Timing
- Row accept to register update: 1 cycle.
- Sixth accept at edge N: `m_at_valid`=1 and the complete `m_at` are visible after edge N.
- `m_at_ack` sampled high at edge M: `m_at_valid`=0 after edge M, and `row_ready`=1 in the cycle after M.
- Minimum word period is ROWS+1 cycles: 6 accept cycles plus at least 1 HOLD cycle.
- Back-to-back rows are accepted every cycle in LOAD; `row_valid` may stay high continuously.
- `row_ready` has a combinational path from state and `clear` only, never from `row_valid`.
- `m_at_ack` held high across the HOLD→LOAD transition has no further effect.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately, `row_ready`=1 once `rst` is released.
- **Basic frame:** rows 3F,00,15,2A,01,20 on consecutive cycles → after the 6th edge, `m_at`=36'hFC056A060, `m_at_valid`=1, `row_count`=0, `frame_count`=1; downstream `N_m_at`=35'h01FD4AFCF.
- **Backpressure:** keep `row_valid`=1 with row 2A during HOLD for 5 cycles → `m_at` stays 36'hFC056A060 and `row_ready`=0. After ack, the next accepted row is 2A and `row_count`=1.
- **Clear mid-word:** accept 3 rows, then `clear` together with `row_valid` → row not accepted, `m_at`=0, `row_count`=0, `frame_count` unchanged.
- **Gapped input:** six rows of 3F with random idle cycles between them → `m_at`=36'hFFFFFFFFF, `m_at_valid` asserted exactly once.
- **Counter wrap:** complete 256 frames with immediate ack → `frame_count` reads 0, and every frame's `m_at_valid` pulse lasts 1 cycle.
